// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and types for the multi-port register file slice.
//   RF_DW  - default register data width
//   RF_AW  - default address width (depth = 2**RF_AW)
//   RF_PCW - default width of the pending-count output (2**RF_PCW > depth)
// Optional feature macro used by importers: RF_WBYPASS_EN (write-to-read bypass).
package rf_pkg;

  localparam int unsigned RF_DW  = 32;
  localparam int unsigned RF_AW  = 4;
  localparam int unsigned RF_PCW = 5;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits for the register file.
// A reservation marks a register pending; a write from either port clears it.
// A reservation and a write to the same register in one cycle leave it pending,
// since the new reservation belongs to a younger instruction than the write.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   wr_a_en_i / wr_a_addr_i    write port A (active-high here)
//   wr_b_en_i / wr_b_addr_i    write port B (active-high here)
//   rsv_en_i / rsv_addr_i      reservation request
//   rd_x/y/z_addr_i            lookup addresses
//   busy_x/y/z_o               pending bit of each lookup address
//   pend_cnt_o                 registered popcount of the pending vector
// Macro RF_WBYPASS_EN: when defined, a lookup hitting a write in flight this
// cycle reports the post-write state (busy only if re-reserved this cycle).
module rf_scoreboard #(
  parameter int unsigned AW  = 4,
  parameter int unsigned PCW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_a_en_i,
  input  logic [AW-1:0] wr_a_addr_i,
  input  logic          wr_b_en_i,
  input  logic [AW-1:0] wr_b_addr_i,
  input  logic          rsv_en_i,
  input  logic [AW-1:0] rsv_addr_i,
  input  logic [AW-1:0] rd_x_addr_i,
  input  logic [AW-1:0] rd_y_addr_i,
  input  logic [AW-1:0] rd_z_addr_i,
  output logic          busy_x_o,
  output logic          busy_y_o,
  output logic          busy_z_o,
  output logic [PCW-1:0] pend_cnt_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [PCW-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] busy_v;

  // Clears applied first so a same-cycle reservation overrides them.
  always_comb begin
    pend_d = pend_q;
    if (wr_a_en_i) pend_d[wr_a_addr_i] = 1'b0;
    if (wr_b_en_i) pend_d[wr_b_addr_i] = 1'b0;
    if (rsv_en_i)  pend_d[rsv_addr_i]  = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + PCW'(pend_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    busy_v = pend_q;
`ifdef RF_WBYPASS_EN
    // Registers written this cycle look free unless re-reserved in the same cycle.
    if (wr_a_en_i) busy_v[wr_a_addr_i] = rsv_en_i && (rsv_addr_i == wr_a_addr_i);
    if (wr_b_en_i) busy_v[wr_b_addr_i] = rsv_en_i && (rsv_addr_i == wr_b_addr_i);
`endif
  end

  assign busy_x_o   = busy_v[rd_x_addr_i];
  assign busy_y_o   = busy_v[rd_y_addr_i];
  assign busy_z_o   = busy_v[rd_z_addr_i];
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: DW x 2**AW general register file with two write ports,
// three combinational read ports and a pending-write scoreboard.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   WEN_A/WA_A/W_DA              write port A (ALU write-back), WEN active-low
//   WEN_B/WA_B/W_DB              write port B (load write-back), WEN active-low
//   RA_A/RA_B/RA_C               read addresses -> GRF_X/GRF_Y/GRF_Z
//   RSV_EN/RSV_A                 reserve (mark pending) request
//   BUSY_X/BUSY_Y/BUSY_Z         pending bit of each read address
//   PEND_CNT                     registered count of pending registers
// Same-address writes on both ports: port B wins.
// Macro RF_WBYPASS_EN: when defined, reads return data being written this
// cycle (port B first); when undefined, reads see stored state only.
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int unsigned DW  = RF_DW,
  parameter int unsigned AW  = RF_AW,
  parameter int unsigned PCW = RF_PCW
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           WEN_A,
  input  logic [AW-1:0]  WA_A,
  input  logic [DW-1:0]  W_DA,
  input  logic           WEN_B,
  input  logic [AW-1:0]  WA_B,
  input  logic [DW-1:0]  W_DB,
  input  logic [AW-1:0]  RA_A,
  input  logic [AW-1:0]  RA_B,
  input  logic [AW-1:0]  RA_C,
  output logic [DW-1:0]  GRF_X,
  output logic [DW-1:0]  GRF_Y,
  output logic [DW-1:0]  GRF_Z,
  input  logic           RSV_EN,
  input  logic [AW-1:0]  RSV_A,
  output logic           BUSY_X,
  output logic           BUSY_Y,
  output logic           BUSY_Z,
  output logic [PCW-1:0] PEND_CNT
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          wr_a_en, wr_b_en;

  assign wr_a_en = ~WEN_A;
  assign wr_b_en = ~WEN_B;

  // Port B applied last so it overrides port A on an address collision.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_a_en) mem_d[WA_A] = W_DA;
    if (wr_b_en) mem_d[WA_B] = W_DB;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef RF_WBYPASS_EN
  function automatic logic [DW-1:0] rd_fwd(
    input logic [DW-1:0] stored,
    input logic [AW-1:0] ra,
    input logic          a_en,
    input logic [AW-1:0] a_addr,
    input logic [DW-1:0] a_data,
    input logic          b_en,
    input logic [AW-1:0] b_addr,
    input logic [DW-1:0] b_data
  );
    logic [DW-1:0] r;
    r = stored;
    if (a_en && (a_addr == ra)) r = a_data;
    if (b_en && (b_addr == ra)) r = b_data;
    return r;
  endfunction

  assign GRF_X = rd_fwd(mem_q[RA_A], RA_A, wr_a_en, WA_A, W_DA, wr_b_en, WA_B, W_DB);
  assign GRF_Y = rd_fwd(mem_q[RA_B], RA_B, wr_a_en, WA_A, W_DA, wr_b_en, WA_B, W_DB);
  assign GRF_Z = rd_fwd(mem_q[RA_C], RA_C, wr_a_en, WA_A, W_DA, wr_b_en, WA_B, W_DB);
`else
  assign GRF_X = mem_q[RA_A];
  assign GRF_Y = mem_q[RA_B];
  assign GRF_Z = mem_q[RA_C];
`endif

  rf_scoreboard #(
    .AW  (AW),
    .PCW (PCW)
  ) u_sb (
    .clk_i       (CLK),
    .rst_i       (RST),
    .wr_a_en_i   (wr_a_en),
    .wr_a_addr_i (WA_A),
    .wr_b_en_i   (wr_b_en),
    .wr_b_addr_i (WA_B),
    .rsv_en_i    (RSV_EN),
    .rsv_addr_i  (RSV_A),
    .rd_x_addr_i (RA_A),
    .rd_y_addr_i (RA_B),
    .rd_z_addr_i (RA_C),
    .busy_x_o    (BUSY_X),
    .busy_y_o    (BUSY_Y),
    .busy_z_o    (BUSY_Z),
    .pend_cnt_o  (PEND_CNT)
  );

endmodule
